// File: rtl/us_stack_pkg.sv
// Shared ICMP constants, receive FSM state encoding and a tkeep byte-count helper.
package us_stack_pkg;

  localparam logic [7:0] ICMP_TYPE_ECHO_REQ   = 8'd8;
  localparam logic [7:0] ICMP_TYPE_ECHO_REPLY = 8'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_CHK,
    ST_PAYLOAD,
    ST_CHECK,
    ST_REQ,
    ST_DRAIN,
    ST_DROP
  } icmp_rx_state_e;

  function automatic logic [3:0] keep_bytes(input logic [7:0] keep);
    keep_bytes = '0;
    for (int i = 0; i < 8; i++) begin
      keep_bytes = keep_bytes + {3'd0, keep[i]};
    end
  endfunction

endpackage

// File: rtl/us_icmp_buf.sv
// Echo payload store: simple dual-port RAM of {last, keep, data}, registered read, rewindable write pointer.
// Reads of an empty buffer return keep=0/last=0; a full buffer reports full and the writer must not write.
module us_icmp_buf #(
  parameter int DEPTH = 256,
  parameter int PW    = 9
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [72:0]   wr_dat_i,
  input  logic          rewind_i,
  input  logic [PW-1:0] rewind_ptr_i,
  input  logic          rd_en_i,
  output logic          full_o,
  output logic          empty_o,
  output logic          rd_is_last_o,
  output logic [PW-1:0] wr_ptr_o,
  output logic [63:0]   rd_dat_o,
  output logic [7:0]    rd_keep_o,
  output logic          rd_last_o
);

  localparam int AW = PW - 1;

  logic [72:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [63:0]   rd_dat_q;
  logic [7:0]    rd_keep_q;
  logic          rd_last_q;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign wr_addr      = wr_ptr_q[AW-1:0];
  assign rd_addr      = rd_ptr_q[AW-1:0];
  assign empty_o      = (wr_ptr_q == rd_ptr_q);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_o       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_addr == rd_addr);
  assign rd_is_last_o = ((rd_ptr_q + PW'(1)) == wr_ptr_q);
  assign wr_ptr_o     = wr_ptr_q;
  assign rd_dat_o     = rd_dat_q;
  assign rd_keep_o    = rd_keep_q;
  assign rd_last_o    = rd_last_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr] <= wr_dat_i;
    end
    if (rd_en_i) begin
      rd_dat_q <= mem_q[rd_addr][63:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_keep_q <= '0;
      rd_last_q <= 1'b0;
    end else begin
      if (rewind_i) begin
        wr_ptr_q <= rewind_ptr_i;
      end else if (wr_en_i) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (rd_en_i) begin
        if (empty_o) begin
          rd_keep_q <= '0;
          rd_last_q <= 1'b0;
        end else begin
          rd_keep_q <= mem_q[rd_addr][71:64];
          rd_last_q <= mem_q[rd_addr][72];
          rd_ptr_q  <= rd_ptr_q + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/us_icmp_rx.sv
// ICMP echo-request receiver: buffers payload, raises icmp_reply_req 2 cycles after tlast; never back-pressures,
// frames arriving while a reply is pending are discarded. Define US_ICMP_CSUM_EN to verify the ICMP checksum.
module us_icmp_rx
  import us_stack_pkg::*;
#(
  parameter int BUF_DEPTH    = 256,
  parameter int MAX_DATA_LEN = 1472
) (
  input  logic        rx_axis_aclk,
  input  logic        rx_axis_areset,
  input  logic [63:0] ip2icmp_axis_tdata,
  input  logic [7:0]  ip2icmp_axis_tkeep,
  input  logic        ip2icmp_axis_tvalid,
  input  logic        ip2icmp_axis_tlast,
  input  logic        ip2icmp_axis_tuser,
  input  logic [31:0] recv_src_ip_addr,
  output logic        icmp_reply_req,
  input  logic        icmp_reply_ack,
  output logic [15:0] echo_id,
  output logic [15:0] echo_seq,
  output logic [31:0] echo_src_ip,
  output logic [15:0] echo_data_len,
  input  logic        icmp_buf_rd_en,
  output logic [63:0] icmp_buf_rd_data,
  output logic [7:0]  icmp_buf_rd_keep,
  output logic        icmp_buf_rd_last,
  output logic [15:0] icmp_drop_cnt
);

  localparam int          PW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_DATA_LEN);

  icmp_rx_state_e state_q, state_d, cur_state;
  logic [15:0]    id_q, id_d, seq_q, seq_d, len_q, len_d, drop_q, drop_d;
  logic [31:0]    src_q, src_d;
  logic           err_q, err_d, disc_q, disc_d;
  logic [PW-1:0]  snap_q, snap_d, buf_wr_ptr;
  logic           buf_full, buf_empty, buf_rd_is_last;
  logic           start_beat, pay_beat, busy, hdr_ok, frame_bad, csum_bad;
  logic           buf_wr_en, rd_go, rewind;
  logic [1:0]     drop_inc;
  logic [16:0]    drop_sum;

  assign start_beat = ip2icmp_axis_tvalid && (state_q == ST_IDLE) && !disc_q;
  assign pay_beat   = ip2icmp_axis_tvalid && (state_q == ST_PAYLOAD);
  assign busy       = (state_q == ST_CHECK) || (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign hdr_ok     = (ip2icmp_axis_tdata[7:0] == ICMP_TYPE_ECHO_REQ) && (ip2icmp_axis_tdata[15:8] == 8'd0);
  assign buf_wr_en  = pay_beat && !buf_full;
  assign rd_go      = icmp_buf_rd_en && (state_q == ST_DRAIN);
  assign frame_bad  = err_q || (len_q > MAX_LEN) || csum_bad;
  assign rewind     = (state_q == ST_CHECK) && frame_bad;

`ifdef US_ICMP_CSUM_EN
  logic [31:0] csum_q, csum_d;
  logic [16:0] csum_f1;
  logic [15:0] csum_f2;

  function automatic logic [31:0] beat_sum(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
    end
    beat_sum = '0;
    // Lane 2w is the high byte of big-endian word w; a missing odd byte pads the low half with zero.
    for (int w = 0; w < 4; w++) begin
      beat_sum = beat_sum + {16'd0, m[16*w +: 8], m[16*w+8 +: 8]};
    end
  endfunction

  always_comb begin
    csum_d = csum_q;
    if (start_beat) begin
      csum_d = beat_sum(ip2icmp_axis_tdata, ip2icmp_axis_tkeep);
    end else if (pay_beat) begin
      csum_d = csum_q + beat_sum(ip2icmp_axis_tdata, ip2icmp_axis_tkeep);
    end
  end

  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_areset) csum_q <= '0;
    else                csum_q <= csum_d;
  end

  assign csum_f1  = {1'b0, csum_q[15:0]} + {1'b0, csum_q[31:16]};
  assign csum_f2  = csum_f1[15:0] + {15'd0, csum_f1[16]};
  assign csum_bad = (csum_f2 != 16'hFFFF);
`else
  assign csum_bad = 1'b0;
`endif

  // HDR_CHK is never registered: it is IDLE seen with beat 0 on the bus.
  always_comb begin
    cur_state = state_q;
    if (start_beat) cur_state = ST_HDR_CHK;
    state_d = state_q;
    case (cur_state)
      ST_IDLE:    state_d = ST_IDLE;
      ST_HDR_CHK: begin
        if (hdr_ok) state_d = ip2icmp_axis_tlast ? ST_CHECK : ST_PAYLOAD;
        else        state_d = ip2icmp_axis_tlast ? ST_IDLE : ST_DROP;
      end
      ST_PAYLOAD: if (ip2icmp_axis_tvalid && ip2icmp_axis_tlast) state_d = ST_CHECK;
      ST_CHECK:   state_d = frame_bad ? ST_IDLE : ST_REQ;
      ST_REQ:     if (icmp_reply_ack) state_d = ST_DRAIN;
      ST_DRAIN:   if (buf_empty || (rd_go && buf_rd_is_last)) state_d = ST_IDLE;
      ST_DROP:    if (ip2icmp_axis_tvalid && ip2icmp_axis_tlast) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    id_d     = id_q;
    seq_d    = seq_q;
    src_d    = src_q;
    len_d    = len_q;
    err_d    = err_q;
    snap_d   = snap_q;
    disc_d   = disc_q;
    drop_inc = 2'd0;
    if (start_beat) begin
      id_d   = {ip2icmp_axis_tdata[39:32], ip2icmp_axis_tdata[47:40]};
      seq_d  = {ip2icmp_axis_tdata[55:48], ip2icmp_axis_tdata[63:56]};
      src_d  = recv_src_ip_addr;
      len_d  = '0;
      err_d  = ip2icmp_axis_tuser;
      snap_d = buf_wr_ptr;
      if (!hdr_ok) drop_inc = drop_inc + 2'd1;
    end
    if (pay_beat) begin
      len_d = len_q + {12'd0, keep_bytes(ip2icmp_axis_tkeep)};
      if (ip2icmp_axis_tuser || buf_full) err_d = 1'b1;
    end
    if (rewind) drop_inc = drop_inc + 2'd1;
    // A frame that starts while a reply is outstanding is swallowed up to its tlast.
    if (ip2icmp_axis_tvalid && (disc_q || busy)) begin
      disc_d = !ip2icmp_axis_tlast;
      if (!disc_q) drop_inc = drop_inc + 2'd1;
    end
  end

  assign drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};
  assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_areset) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      seq_q   <= '0;
      src_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      snap_q  <= '0;
      disc_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      seq_q   <= seq_d;
      src_q   <= src_d;
      len_q   <= len_d;
      err_q   <= err_d;
      snap_q  <= snap_d;
      disc_q  <= disc_d;
      drop_q  <= drop_d;
    end
  end

  us_icmp_buf #(
    .DEPTH (BUF_DEPTH),
    .PW    (PW)
  ) u_buf (
    .clk_i        (rx_axis_aclk),
    .rst_i        (rx_axis_areset),
    .wr_en_i      (buf_wr_en),
    .wr_dat_i     ({ip2icmp_axis_tlast, ip2icmp_axis_tkeep, ip2icmp_axis_tdata}),
    .rewind_i     (rewind),
    .rewind_ptr_i (snap_q),
    .rd_en_i      (rd_go),
    .full_o       (buf_full),
    .empty_o      (buf_empty),
    .rd_is_last_o (buf_rd_is_last),
    .wr_ptr_o     (buf_wr_ptr),
    .rd_dat_o     (icmp_buf_rd_data),
    .rd_keep_o    (icmp_buf_rd_keep),
    .rd_last_o    (icmp_buf_rd_last)
  );

  assign icmp_reply_req = (state_q == ST_REQ);
  assign echo_id        = id_q;
  assign echo_seq       = seq_q;
  assign echo_src_ip    = src_q;
  assign echo_data_len  = len_q;
  assign icmp_drop_cnt  = drop_q;

endmodule

// File: tb/tb_us_icmp_rx.sv
// Self-checking bench for us_icmp_rx: table vectors, hand-written corner sequences and randomized frames.
module tb_us_icmp_rx;

`ifdef US_ICMP_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tlast, tuser;
  logic [31:0] src;
  logic        req, ack;
  logic [15:0] eid, eseq, elen, dcnt;
  logic [31:0] esrc;
  logic        rd_en;
  logic [63:0] rd_data;
  logic [7:0]  rd_keep;
  logic        rd_last;

  int vecs = 0;
  int errs = 0;
  int exp_drop = 0;
  byte unsigned pl [0:2047];

  always #5 clk = ~clk;

  us_icmp_rx dut (
    .rx_axis_aclk        (clk),
    .rx_axis_areset      (rst),
    .ip2icmp_axis_tdata  (tdata),
    .ip2icmp_axis_tkeep  (tkeep),
    .ip2icmp_axis_tvalid (tvalid),
    .ip2icmp_axis_tlast  (tlast),
    .ip2icmp_axis_tuser  (tuser),
    .recv_src_ip_addr    (src),
    .icmp_reply_req      (req),
    .icmp_reply_ack      (ack),
    .echo_id             (eid),
    .echo_seq            (eseq),
    .echo_src_ip         (esrc),
    .echo_data_len       (elen),
    .icmp_buf_rd_en      (rd_en),
    .icmp_buf_rd_data    (rd_data),
    .icmp_buf_rd_keep    (rd_keep),
    .icmp_buf_rd_last    (rd_last),
    .icmp_drop_cnt       (dcnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tkeep = '0; tdata = '0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
  endtask

  // Internet checksum over header words and big-endian payload words, odd byte zero-padded.
  function automatic logic [15:0] csum_of(input logic [7:0] ty, input logic [7:0] co,
                                          input logic [15:0] id, input logic [15:0] sq, input int n);
    int unsigned s;
    s = 32'({ty, co}) + 32'(id) + 32'(sq);
    for (int i = 0; i < n; i += 2) s += 32'({pl[i], (i + 1 < n) ? pl[i+1] : 8'h00});
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  function automatic bit model_good(input logic [7:0] ty, input logic [7:0] co, input int n,
                                    input bit tu, input bit cor);
    return (ty == 8'd8) && (co == 8'd0) && !tu && (n <= 1472) && (((n + 7) / 8) <= 256)
           && !(CSUM_EN && cor);
  endfunction

  task automatic send_frame(input logic [7:0] ty, input logic [7:0] co, input logic [15:0] id,
                            input logic [15:0] sq, input int n, input bit tu, input bit cor, input int cut);
    logic [15:0] cs;
    int nb;
    cs = csum_of(ty, co, id, sq, n);
    if (cor) cs = cs ^ 16'h0001;
    nb = (n + 7) / 8;
    tvalid = 1'b1;
    tdata  = {sq[7:0], sq[15:8], id[7:0], id[15:8], cs[7:0], cs[15:8], co, ty};
    tkeep  = 8'hFF;
    tlast  = (nb == 0);
    tuser  = tu && (nb == 0);
    step();
    for (int b = 0; b < nb && b < cut; b++) begin
      for (int j = 0; j < 8; j++) begin
        tdata[8*j +: 8] = (8*b + j < n) ? pl[8*b + j] : 8'h00;
        tkeep[j]        = (8*b + j < n);
      end
      tlast = (b == nb - 1);
      tuser = tu && (b == nb - 1);
      step();
    end
  endtask

  task automatic drain(input int n);
    int nb;
    logic [63:0] ed;
    logic [7:0]  ek;
    nb = (n + 7) / 8;
    if (nb == 0) begin
      rd_en = 1'b1; step(); rd_en = 1'b0;
      chk("rd_keep_past_last", 64'(rd_keep), 64'(8'h00));
      chk("rd_last_past_last", 64'(rd_last), 64'(1'b0));
    end
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 8; j++) begin
        ed[8*j +: 8] = (8*b + j < n) ? pl[8*b + j] : 8'h00;
        ek[j]        = (8*b + j < n);
      end
      rd_en = 1'b1; step();
      chk("rd_data", rd_data, ed);
      chk("rd_keep", 64'(rd_keep), 64'(ek));
      chk("rd_last", 64'(rd_last), 64'(b == nb - 1));
    end
    rd_en = 1'b0;
  endtask

  task automatic run_echo(input logic [7:0] ty, input logic [7:0] co, input logic [15:0] id,
                          input logic [15:0] sq, input logic [31:0] s_ip, input int n,
                          input bit tu, input bit cor, input bit eg, input logic [15:0] elen_exp);
    int hold;
    src = s_ip;
    fill(n);
    send_frame(ty, co, id, sq, n, tu, cor, 1 << 20);
    idle_bus();
    src = $urandom;
    chk("req_in_check", 64'(req), 64'(1'b0));
    step();
    chk("req_after_tlast", 64'(req), 64'(eg));
    if (!eg) begin
      exp_drop++;
      chk("drop_cnt", 64'(dcnt), 64'(exp_drop));
    end else begin
      chk("drop_cnt_good", 64'(dcnt), 64'(exp_drop));
      chk("echo_id", 64'(eid), 64'(id));
      chk("echo_seq", 64'(eseq), 64'(sq));
      chk("echo_src_ip", 64'(esrc), 64'(s_ip));
      chk("echo_data_len", 64'(elen), 64'(elen_exp));
      hold = $urandom_range(0, 3);
      repeat (hold) begin step(); chk("req_hold", 64'(req), 64'(1'b1)); end
      ack = 1'b1; step(); ack = 1'b0;
      chk("req_fall", 64'(req), 64'(1'b0));
      drain(n);
    end
  endtask

  typedef struct {
    logic [7:0]  ty;
    logic [7:0]  co;
    int          n;
    bit          tu;
    bit          cor;
    bit          exp_req;
    logic [15:0] exp_len;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0]  ty, co;
    logic [15:0] sid;
    int          n;
    bit          tu, cor, g;

    tbl[0] = '{8'd8, 8'd0,   32, 1'b0, 1'b0, 1'b1, 16'd32};
    tbl[1] = '{8'd0, 8'd0,   20, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{8'd8, 8'd0,   13, 1'b0, 1'b0, 1'b1, 16'd13};
    tbl[3] = '{8'd8, 8'd0,    0, 1'b0, 1'b0, 1'b1, 16'd0};
    tbl[4] = '{8'd8, 8'd0,   40, 1'b1, 1'b0, 1'b0, 16'd0};
    tbl[5] = '{8'd8, 8'd1,    8, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[6] = '{8'd8, 8'd0, 1472, 1'b0, 1'b0, 1'b1, 16'd1472};
    tbl[7] = '{8'd8, 8'd0, 1473, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[8] = '{8'd8, 8'd0,   24, 1'b0, 1'b1, !CSUM_EN, 16'd24};
    tbl[9] = '{8'd3, 8'd0,    0, 1'b0, 1'b0, 1'b0, 16'd0};

    rst = 1'b1; ack = 1'b0; rd_en = 1'b0; src = '0;
    idle_bus();
    repeat (3) step();
    rst = 1'b0;
    chk("rst_req", 64'(req), 64'(1'b0));
    chk("rst_drop_cnt", 64'(dcnt), 64'(16'd0));
    chk("rst_echo_id", 64'(eid), 64'(16'd0));
    chk("rst_echo_seq", 64'(eseq), 64'(16'd0));
    chk("rst_echo_src", 64'(esrc), 64'(32'd0));
    chk("rst_echo_len", 64'(elen), 64'(16'd0));
    chk("rst_rd_keep", 64'(rd_keep), 64'(8'd0));
    chk("rst_rd_last", 64'(rd_last), 64'(1'b0));

    for (int i = 0; i < 10; i++) begin
      run_echo(tbl[i].ty, tbl[i].co, (i == 0) ? 16'h1234 : 16'($urandom), 16'(i + 1),
               (i == 0) ? 32'hC0A8_010A : $urandom, tbl[i].n, tbl[i].tu, tbl[i].cor,
               tbl[i].exp_req, tbl[i].exp_len);
    end

    // A dropped frame's tlast immediately followed by a new beat 0.
    tvalid = 1'b1; tkeep = 8'hFF; tuser = 1'b0;
    tdata = 64'h0; tlast = 1'b0; step();
    tdata = {$urandom, $urandom}; tlast = 1'b1; step();
    exp_drop++;
    run_echo(8'd8, 8'd0, 16'hBEEF, 16'h0042, 32'h0A00_0001, 21, 1'b0, 1'b0, 1'b1, 16'd21);

    // Second echo while the first request is pending for 10 cycles.
    src = 32'h0A01_0203;
    fill(32);
    send_frame(8'd8, 8'd0, 16'hAAAA, 16'h5555, 32, 1'b0, 1'b0, 1 << 20);
    idle_bus();
    step();
    chk("seq37_req", 64'(req), 64'(1'b1));
    send_frame(8'd8, 8'd0, 16'h7777, 16'h8888, 16, 1'b0, 1'b0, 1 << 20);
    idle_bus();
    exp_drop++;
    chk("seq37_drop_cnt", 64'(dcnt), 64'(exp_drop));
    repeat (7) begin
      chk("seq37_req_held", 64'(req), 64'(1'b1));
      chk("seq37_id_held", 64'(eid), 64'(16'hAAAA));
      step();
    end
    chk("seq37_seq_held", 64'(eseq), 64'(16'h5555));
    chk("seq37_src_held", 64'(esrc), 64'(32'h0A01_0203));
    chk("seq37_len_held", 64'(elen), 64'(16'd32));
    ack = 1'b1; step(); ack = 1'b0;
    chk("seq37_req_fall", 64'(req), 64'(1'b0));
    drain(32);

    for (int r = 0; r < 25; r++) begin
      ty  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd8;
      co  = ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0;
      n   = $urandom_range(0, 100);
      tu  = ($urandom_range(0, 7) == 0);
      cor = ($urandom_range(0, 5) == 0);
      g   = model_good(ty, co, n, tu, cor);
      sid = 16'($urandom);
      run_echo(ty, co, sid, 16'(r), $urandom, n, tu, cor, g, 16'(n));
    end

    // Reset while a frame is in PAYLOAD.
    src = 32'h0102_0304;
    fill(64);
    send_frame(8'd8, 8'd0, 16'h0101, 16'h0202, 64, 1'b0, 1'b0, 2);
    idle_bus();
    rst = 1'b1; step(); rst = 1'b0;
    exp_drop = 0;
    repeat (4) begin
      chk("rst_mid_req", 64'(req), 64'(1'b0));
      step();
    end
    chk("rst_mid_drop_cnt", 64'(dcnt), 64'(16'd0));
    run_echo(8'd8, 8'd0, 16'h4321, 16'h0009, 32'hC0A8_0101, 48, 1'b0, 1'b0, 1'b1, 16'd48);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
